// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode constants, register index type and field extractors
package riscv_pkg;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef logic [4:0] reg_idx_t;

    function automatic logic [6:0] get_opcode(input logic [31:0] insn);
        return insn[6:0];
    endfunction

    function automatic logic [2:0] get_funct3(input logic [31:0] insn);
        return insn[14:12];
    endfunction

    function automatic logic [6:0] get_funct7(input logic [31:0] insn);
        return insn[31:25];
    endfunction

    function automatic reg_idx_t get_rd(input logic [31:0] insn);
        return insn[11:7];
    endfunction

    function automatic reg_idx_t get_rs1(input logic [31:0] insn);
        return insn[19:15];
    endfunction

    function automatic reg_idx_t get_rs2(input logic [31:0] insn);
        return insn[24:20];
    endfunction

    function automatic logic [19:0] get_uimm(input logic [31:0] insn);
        return insn[31:12];
    endfunction

endpackage

// File: rtl/riscv_insn_decode_if.sv
// rtl/riscv_insn_decode_if.sv - fetch, writeback and exec-side signals of the decode stage
interface riscv_insn_decode_if
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      insn;

    logic             wb_en;
    reg_idx_t         wb_addr;
    logic [XLEN-1:0]  wb_data;

    logic             out_valid;
    logic             out_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    reg_idx_t         rd_addr;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic             illegal;

    // slave is the decode stage; master is the surrounding fetch/exec environment
    modport slave (
        input  in_valid, insn, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, opcode, funct3, funct7, rd_addr, rs1, rs2, imm, illegal
    );

    modport master (
        output in_valid, insn, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, opcode, funct3, funct7, rd_addr, rs1, rs2, imm, illegal
    );

endinterface

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 2-read 1-write integer register file, x0 reads zero
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  reg_idx_t         raddr1,
    input  reg_idx_t         raddr2,
    output logic [XLEN-1:0]  rdata1,
    output logic [XLEN-1:0]  rdata2,
    input  logic             we,
    input  reg_idx_t         waddr,
    input  logic [XLEN-1:0]  wdata
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // reads see the old value during a same-cycle write; forwarding lives in the decode stage
    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/riscv_insn_decode.sv
// rtl/riscv_insn_decode.sv - decode/issue stage with scoreboard; RISCV_DECODE_BYPASS_EN forwards writeback data
module riscv_insn_decode
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
)
(
    input  logic                 clock,
    input  logic                 reset_n,
    riscv_insn_decode_if.slave   bus
);

    logic [6:0]       opc;
    reg_idx_t         src1_idx;
    reg_idx_t         src2_idx;
    reg_idx_t         dst_idx;
    logic             legal;
    logic             fwd1;
    logic             fwd2;
    logic             hazard;
    logic             accept;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [XLEN-1:0]  rf_rd1;
    logic [XLEN-1:0]  rf_rd2;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic signed [31:0] uimm;
    logic [XLEN-1:0]  imm_ext;

    logic             out_valid_q;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;
    reg_idx_t         rd_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  imm_q;
    logic             illegal_q;

    assign opc      = get_opcode(bus.insn);
    assign src1_idx = get_rs1(bus.insn);
    assign src2_idx = get_rs2(bus.insn);
    assign dst_idx  = get_rd(bus.insn);
    assign legal    = (opc == OPC_OP) || (opc == OPC_LUI);

`ifdef RISCV_DECODE_BYPASS_EN
    assign fwd1 = bus.wb_en && (bus.wb_addr == src1_idx) && (src1_idx != '0);
    assign fwd2 = bus.wb_en && (bus.wb_addr == src2_idx) && (src2_idx != '0);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // a forwarded source no longer blocks; the destination check (WAW) is never masked
    assign hazard = legal && ((busy[src1_idx] && !fwd1) ||
                              (busy[src2_idx] && !fwd2) ||
                              (busy[dst_idx] && dst_idx != '0));

    assign bus.in_ready = reset_n && (!out_valid_q || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    riscv_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .raddr1  (src1_idx),
        .raddr2  (src2_idx),
        .rdata1  (rf_rd1),
        .rdata2  (rf_rd2),
        .we      (bus.wb_en),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data)
    );

    assign op1 = !legal ? '0 : (fwd1 ? bus.wb_data : rf_rd1);
    assign op2 = !legal ? '0 : (fwd2 ? bus.wb_data : rf_rd2);

    assign uimm    = {get_uimm(bus.insn), 12'b0};
    assign imm_ext = XLEN'(uimm);

    // set after clear so a same-cycle issue to the written index keeps it busy
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_en && bus.wb_addr != '0) begin
            busy_nxt[bus.wb_addr] = 1'b0;
        end
        if (accept && legal && dst_idx != '0) begin
            busy_nxt[dst_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            opcode_q    <= opc;
            funct3_q    <= get_funct3(bus.insn);
            funct7_q    <= get_funct7(bus.insn);
            rd_q        <= dst_idx;
            rs1_q       <= op1;
            rs2_q       <= op2;
            imm_q       <= (opc == OPC_LUI) ? imm_ext : '0;
            illegal_q   <= !legal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = opcode_q;
    assign bus.funct3    = funct3_q;
    assign bus.funct7    = funct7_q;
    assign bus.rd_addr   = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.imm       = imm_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_insn_decode.sv
// tb/tb_riscv_insn_decode.sv - scoreboard bench for riscv_insn_decode
module tb_riscv_insn_decode;
    import riscv_pkg::*;

`ifdef RISCV_DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    riscv_insn_decode_if #(.XLEN(32)) bus ();

    riscv_insn_decode #(.XLEN(32), .NREGS(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        sb[$];
    logic [31:0] m_rf [32];
    logic        m_busy [32];
    bit          last_acc;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit src_busy(input logic [4:0] s);
        return m_busy[s] && !(BYP && bus.wb_en && bus.wb_addr == s && s != 5'd0);
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] s);
        if (BYP && bus.wb_en && bus.wb_addr == s && s != 5'd0) return bus.wb_data;
        return m_rf[s];
    endfunction

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // one clock: check outputs and in_ready at negedge against the model, then advance the model
    task automatic step();
        exp_t        e;
        logic [31:0] w;
        logic [4:0]  s1, s2, rd;
        bit          legal, haz, exp_rdy, acc, con;
        @(negedge clock);
        w  = bus.insn;
        s1 = w[19:15];
        s2 = w[24:20];
        rd = w[11:7];
        legal   = (w[6:0] == OPC_OP) || (w[6:0] == OPC_LUI);
        haz     = legal && (src_busy(s1) || src_busy(s2) || (m_busy[rd] && rd != 5'd0));
        exp_rdy = (sb.size() == 0 || bus.out_ready) && !haz;
        expect_eq("out_valid", bus.out_valid, sb.size() != 0);
        expect_eq("in_ready", bus.in_ready, exp_rdy);
        con = (sb.size() != 0) && bus.out_ready;
        acc = bus.in_valid && exp_rdy;
        if (sb.size() != 0) begin
            e = sb[0];
            expect_eq("opcode",  bus.opcode,  e.opcode);
            expect_eq("funct3",  bus.funct3,  e.funct3);
            expect_eq("funct7",  bus.funct7,  e.funct7);
            expect_eq("rd_addr", bus.rd_addr, e.rd);
            expect_eq("rs1",     bus.rs1,     e.rs1);
            expect_eq("rs2",     bus.rs2,     e.rs2);
            expect_eq("illegal", bus.illegal, e.ill);
            if (!e.ill) expect_eq("imm", bus.imm, e.imm);
        end
        if (con) void'(sb.pop_front());
        if (acc) begin
            e.opcode = w[6:0];
            e.funct3 = w[14:12];
            e.funct7 = w[31:25];
            e.rd     = rd;
            e.rs1    = legal ? src_val(s1) : 32'd0;
            e.rs2    = legal ? src_val(s2) : 32'd0;
            e.imm    = (w[6:0] == OPC_LUI) ? {w[31:12], 12'b0} : 32'd0;
            e.ill    = !legal;
            sb.push_back(e);
        end
        if (bus.wb_en && bus.wb_addr != 5'd0) begin
            m_rf[bus.wb_addr]   = bus.wb_data;
            m_busy[bus.wb_addr] = 1'b0;
        end
        if (acc && legal && rd != 5'd0) m_busy[rd] = 1'b1;
        last_acc = acc;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.insn     = w;
        last_acc     = 1'b0;
        for (int i = 0; i < 20 && !last_acc; i++) step();
        if (!last_acc) expect_eq("accept_timeout", last_acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic writeback(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        step();
        bus.wb_en   = 1'b0;
    endtask

    // hold a dependent insn for two stalled cycles, then release it with a writeback
    task automatic stall_release(input logic [31:0] w, input logic [4:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.insn     = w;
        step();
        step();
        writeback(a, d);
        if (!last_acc) step();
        expect_eq("released", last_acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.insn      = '0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
        model_reset();

        repeat (3) @(negedge clock);
        expect_eq("rst_out_valid", bus.out_valid, 1'b0);
        expect_eq("rst_illegal",   bus.illegal,   1'b0);
        expect_eq("rst_in_ready",  bus.in_ready,  1'b0);
        expect_eq("rst_opcode",    bus.opcode,    7'd0);
        expect_eq("rst_rs1",       bus.rs1,       32'd0);
        expect_eq("rst_imm",       bus.imm,       32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // add x3,x1,x2 then dependent sub x4,x3,x1
        issue(32'h002081B3);
        step();
        stall_release(32'h40118233, 5'd3, 32'd5);
        step();
        writeback(5'd4, 32'd7);
        writeback(5'd1, 32'h11);
        writeback(5'd2, 32'h22);

        // exec backpressure with a second insn waiting
        bus.out_ready = 1'b0;
        issue(32'h00208333);
        bus.in_valid = 1'b1;
        bus.insn     = 32'h003243B3;
        repeat (3) step();
        bus.out_ready = 1'b1;
        step();
        expect_eq("queued_accept", last_acc, 1'b1);
        bus.in_valid = 1'b0;
        step();
        writeback(5'd6, 32'h66);
        writeback(5'd7, 32'h77);

        // LUI, illegal insns ignoring a busy x5, then a RAW on x5
        issue(32'h123452B7);
        issue(32'h000282FF);
        issue(32'hFFFFFFFF);
        issue(32'h00000FB3);
        stall_release(32'h00028433, 5'd5, 32'h55);
        step();

        // x0 writes are dropped and x0 destinations never stall
        writeback(5'd0, 32'hDEAD);
        issue(32'h000004B3);
        bus.in_valid = 1'b1;
        bus.insn     = 32'h00208033;
        step();
        step();
        expect_eq("b2b_second", last_acc, 1'b1);
        bus.in_valid = 1'b0;
        step();

        // asynchronous reset while an insn is held and x3 is busy
        bus.out_ready = 1'b0;
        issue(32'h002081B3);
        #3;
        reset_n = 1'b0;
        #1;
        expect_eq("async_out_valid", bus.out_valid, 1'b0);
        expect_eq("async_in_ready",  bus.in_ready,  1'b0);
        expect_eq("async_rs1",       bus.rs1,       32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        issue(32'h002081B3);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
